// File: rtl/counter_wrap_monitor.sv
// Wrap-event monitor for the 8-bit up/down counter: classifies wraps, keeps saturating tallies
// and runs an armed window that raises a sticky interrupt at a programmable wrap limit.
module counter_wrap_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       count_in,
  input  logic             overflow_in,
  input  logic             arm,
  input  logic             disarm,
  input  logic             ack,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] up_wraps,
  output logic [CNT_W-1:0] down_wraps,
  output logic [CNT_W-1:0] window_wraps,
  output logic             irq,
  output logic [1:0]       state,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    RSVD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           st;
  state_t           cur_st;
  state_t           nxt_st;
  logic             ovf_d;
  logic             primed;
  logic             evt;
  logic             up_evt;
  logic             dn_evt;
  logic             clr;
  logic             win_inc;
  logic             up_full;
  logic             dn_full;
  logic             win_full;
  logic [CNT_W-1:0] up_base;
  logic [CNT_W-1:0] dn_base;
  logic [CNT_W-1:0] win_base;
  logic [CNT_W-1:0] nxt_up;
  logic [CNT_W-1:0] nxt_dn;
  logic [CNT_W-1:0] nxt_win;
  logic             nxt_sat;

  assign state = st;

  // primed masks the first clock after reset so a level already high at release is not an event
  always_comb begin
    evt    = primed & overflow_in & ~ovf_d;
    up_evt = evt & (count_in == 8'h00);
    dn_evt = evt & (count_in == 8'hFF);
    cur_st = (st == ARMED || st == FIRED) ? st : IDLE;
    clr    = ~disarm & arm & (cur_st == IDLE);

    up_base = clr ? '0 : up_wraps;
    dn_base = clr ? '0 : down_wraps;
    up_full = up_evt & (up_base == MAX);
    dn_full = dn_evt & (dn_base == MAX);
    nxt_up  = (up_evt && !up_full) ? up_base + CNT_W'(1) : up_base;
    nxt_dn  = (dn_evt && !dn_full) ? dn_base + CNT_W'(1) : dn_base;

    nxt_st   = cur_st;
    win_base = window_wraps;
    win_inc  = 1'b0;
    if (disarm) begin
      nxt_st = IDLE;
    end else begin
      case (cur_st)
        IDLE: begin
          if (arm) begin
            nxt_st   = ARMED;
            win_base = '0;
            win_inc  = up_evt | dn_evt;
          end
        end
        ARMED: win_inc = up_evt | dn_evt;
        FIRED: begin
          if (ack) begin
            nxt_st   = ARMED;
            win_base = '0;
            win_inc  = up_evt | dn_evt;
          end
        end
        default: nxt_st = IDLE;
      endcase
    end

    win_full = win_inc & (win_base == MAX);
    nxt_win  = (win_inc && !win_full) ? win_base + CNT_W'(1) : win_base;
    if (win_inc && (limit != '0) && (nxt_win >= limit)) begin
      nxt_st = FIRED;
    end

    nxt_sat = (clr ? 1'b0 : sat) | up_full | dn_full | win_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      ovf_d        <= 1'b0;
      primed       <= 1'b0;
      up_wraps     <= '0;
      down_wraps   <= '0;
      window_wraps <= '0;
      irq          <= 1'b0;
      sat          <= 1'b0;
    end else begin
      st           <= nxt_st;
      ovf_d        <= overflow_in;
      primed       <= 1'b1;
      up_wraps     <= nxt_up;
      down_wraps   <= nxt_dn;
      window_wraps <= nxt_win;
      irq          <= (nxt_st == FIRED);
      sat          <= nxt_sat;
    end
  end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Scoreboard bench: a behavioural model predicts both a 16-bit and a 4-bit instance each cycle.
module tb_counter_wrap_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count_in;
  logic        overflow_in, arm, disarm, ack;
  logic [15:0] limit;
  logic [3:0]  limit4;
  logic [15:0] up_a, dn_a, win_a;
  logic        irq_a, sat_a;
  logic [1:0]  st_a;
  logic [3:0]  up_b, dn_b, win_b;
  logic        irq_b, sat_b;
  logic [1:0]  st_b;

  assign limit4 = limit[3:0];

  always #5 clk = ~clk;

  counter_wrap_monitor #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .count_in(count_in), .overflow_in(overflow_in),
    .arm(arm), .disarm(disarm), .ack(ack), .limit(limit),
    .up_wraps(up_a), .down_wraps(dn_a), .window_wraps(win_a),
    .irq(irq_a), .state(st_a), .sat(sat_a));

  counter_wrap_monitor #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .count_in(count_in), .overflow_in(overflow_in),
    .arm(arm), .disarm(disarm), .ack(ack), .limit(limit4),
    .up_wraps(up_b), .down_wraps(dn_b), .window_wraps(win_b),
    .irq(irq_b), .state(st_b), .sat(sat_b));

  typedef struct packed {
    logic [15:0] up;
    logic [15:0] dn;
    logic [15:0] win;
    logic [1:0]  st;
    logic        irq;
    logic        sat;
  } exp_t;

  exp_t exp_q[2][$];

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_up[2], m_dn[2], m_win[2];
  int          m_st[2];
  bit          m_sat[2];
  bit          m_ovf_d, m_primed;

  task automatic chk(input string tag, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int unsigned maxv(input int i);
    return (i == 0) ? 32'd65535 : 32'd15;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_up[i] = 0; m_dn[i] = 0; m_win[i] = 0; m_st[i] = 0; m_sat[i] = 0;
    end
    m_ovf_d  = 0;
    m_primed = 0;
  endtask

  task automatic bump_window(input int i, input int unsigned lim, input bit wrap);
    if (wrap) begin
      if (m_win[i] == maxv(i)) m_sat[i] = 1;
      else m_win[i]++;
      if (lim != 0 && m_win[i] >= lim) m_st[i] = 2;
    end
  endtask

  task automatic model_step(input logic ovf, input logic [7:0] cnt,
                            input logic a, input logic d, input logic k);
    bit evt, u, dw;
    int unsigned lim;
    exp_t e;
    evt      = ovf && !m_ovf_d && m_primed;
    m_ovf_d  = ovf;
    m_primed = 1;
    u  = evt && (cnt == 8'h00);
    dw = evt && (cnt == 8'hFF);
    for (int i = 0; i < 2; i++) begin
      lim = limit & maxv(i);
      if (!d && a && m_st[i] == 0) begin
        m_up[i] = 0; m_dn[i] = 0; m_win[i] = 0; m_sat[i] = 0;
      end
      if (u) begin
        if (m_up[i] == maxv(i)) m_sat[i] = 1; else m_up[i]++;
      end
      if (dw) begin
        if (m_dn[i] == maxv(i)) m_sat[i] = 1; else m_dn[i]++;
      end
      if (d) m_st[i] = 0;
      else if (m_st[i] == 0) begin
        if (a) begin
          m_st[i] = 1;
          bump_window(i, lim, u || dw);
        end
      end else if (m_st[i] == 1) begin
        bump_window(i, lim, u || dw);
      end else if (k) begin
        m_win[i] = 0;
        m_st[i]  = 1;
        bump_window(i, lim, u || dw);
      end
      e.up  = m_up[i][15:0];
      e.dn  = m_dn[i][15:0];
      e.win = m_win[i][15:0];
      e.st  = m_st[i][1:0];
      e.irq = (m_st[i] == 2);
      e.sat = m_sat[i];
      exp_q[i].push_back(e);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q[0].size() == 0 || exp_q[1].size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q[0].pop_front();
      chk("up16", up_a, e.up);   chk("dn16", dn_a, e.dn);  chk("win16", win_a, e.win);
      chk("st16", st_a, e.st);   chk("irq16", irq_a, e.irq); chk("sat16", sat_a, e.sat);
      e = exp_q[1].pop_front();
      chk("up4", up_b, e.up);    chk("dn4", dn_b, e.dn);   chk("win4", win_b, e.win);
      chk("st4", st_b, e.st);    chk("irq4", irq_b, e.irq); chk("sat4", sat_b, e.sat);
    end
  endtask

  task automatic step(input logic ovf, input logic [7:0] cnt,
                      input logic a = 1'b0, input logic d = 1'b0, input logic k = 1'b0);
    overflow_in = ovf; count_in = cnt; arm = a; disarm = d; ack = k;
    model_step(ovf, cnt, a, d, k);
    @(posedge clk);
    #1;
    compare_outputs();
    arm = 1'b0; disarm = 1'b0; ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {up_a, dn_a, win_a, irq_a, st_a, sat_a} == '0, 1);
    chk({tag, "_b"}, {up_b, dn_b, win_b, irq_b, st_b, sat_b} == '0, 1);
  endtask

  initial begin
    rst = 1'b1; overflow_in = 1'b0; count_in = 8'h00;
    arm = 1'b0; disarm = 1'b0; ack = 1'b0; limit = 16'd0;
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // three up-wraps in a window with limit 4
    step(0, 8'h00); step(0, 8'h00);
    limit = 16'd4;
    step(0, 8'h00, 1);
    repeat (3) begin step(1, 8'h00); step(0, 8'h00); end
    chk("t1_up", up_a, 3); chk("t1_win", win_a, 3); chk("t1_dn", dn_a, 0); chk("t1_irq", irq_a, 0);

    // limit 2 with down-wraps, extra event while fired, then ack
    limit = 16'd2;
    step(0, 8'hFF, 0, 1);
    step(0, 8'hFF, 1);
    step(1, 8'hFF); step(0, 8'hFF); step(1, 8'hFF);
    chk("t2_irq", irq_a, 1); chk("t2_state", st_a, 2);
    step(0, 8'hFF); step(1, 8'hFF);
    chk("t2_dn", dn_a, 3); chk("t2_win", win_a, 2);
    step(0, 8'hFF); step(0, 8'hFF, 0, 0, 1);
    chk("t2_ack_irq", irq_a, 0); chk("t2_ack_win", win_a, 0);

    // held level counts once; glitch value ignored
    repeat (10) step(1, 8'h00);
    step(0, 8'h00); step(1, 8'h37);
    chk("t3_up", up_a, 1); chk("t3_dn", dn_a, 3); chk("t3_win", win_a, 1);
    step(0, 8'h37);

    // ack coincident with an event at limit 1 stays fired
    limit = 16'd1;
    step(1, 8'h00); step(0, 8'h00);
    step(1, 8'h00, 0, 0, 1);
    chk("t4_state", st_a, 2); chk("t4_irq", irq_a, 1); chk("t4_win", win_a, 1);
    step(0, 8'h00);

    // saturation on the 4-bit instance
    limit = 16'd0;
    step(0, 8'h00, 0, 1); step(0, 8'h00, 1);
    repeat (16) begin step(1, 8'h00); step(0, 8'h00); end
    chk("t5_up4", up_b, 15); chk("t5_sat4", sat_b, 1);
    chk("t5_up16", up_a, 16); chk("t5_sat16", sat_a, 0);
    step(0, 8'h00, 0, 1);
    chk("t5_disarm_up4", up_b, 15); chk("t5_disarm_sat4", sat_b, 1);
    step(0, 8'h00, 1);
    chk("t5_arm_up4", up_b, 0); chk("t5_arm_sat4", sat_b, 0);

    // reset mid-window with the overflow level held high
    limit = 16'd4;
    step(1, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) step(1, 8'h00);
    chk("t6_masked_up", up_a, 0); chk("t6_state", st_a, 0);
    step(0, 8'h00); step(1, 8'h00);
    chk("t6_up", up_a, 1);

    // randomised mix of controls, limits and counter values
    for (int n = 0; n < 400; n++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 2);
      c = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'h37;
      if ($urandom_range(0, 15) == 0) limit = 16'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), c,
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_wrap_monitor.md
# counter_wrap_monitor

Downstream monitor for the 8-bit up/down counter. It consumes the counter's `count` and `overflow` outputs and detects each wrap event. It classifies each wrap as an up-wrap (FF→00) or a down-wrap (00→FF) and keeps saturating lifetime tallies of each. An armed window counts wraps toward a programmable limit and raises a sticky interrupt when the limit is reached; firmware acknowledges the interrupt with a pulse.

## Interface
- `CNT_W`, default 16: width of all wrap tallies and of `limit`.
- `clk`  input  1  rising-edge clock shared with the counter.
- `rst`  input  1  asynchronous, active-high reset.
- `count_in`  input  8  the counter's `count` output.
- `overflow_in`  input  1  the counter's registered `overflow` output. It is high after a wrap and can stay high while the counter is disabled.
- `arm`  input  1  single-cycle pulse: start a window from IDLE.
- `disarm`  input  1  single-cycle pulse: return to IDLE from any state.
- `ack`  input  1  single-cycle pulse: acknowledge the interrupt in FIRED.
- `limit`  input  CNT_W  window wrap limit. Sampled on each event. 0 means the block never fires.
- `up_wraps`  output  CNT_W  saturating count of up-wraps.
- `down_wraps`  output  CNT_W  saturating count of down-wraps.
- `window_wraps`  output  CNT_W  saturating count of wraps in the current window.
- `irq`  output  1  sticky interrupt, high only in FIRED.
- `state`  output  2  encoding: IDLE=0, ARMED=1, FIRED=2. The value 3 is unused and decodes to IDLE.
- `sat`  output  1  sticky flag: some tally has saturated.

## Operation
- Event detection:
  - `ovf_d` is a register holding the previous `overflow_in`.
  - A wrap event is `evt = overflow_in & ~ovf_d`. A level held high produces exactly one event.
- Direction on an event:
  - `count_in == 8'h00` is an up-wrap.
  - `count_in == 8'hFF` is a down-wrap.
  - Any other value is a glitch. It is ignored and changes no output.
- Lifetime tallies:
  - `up_wraps` and `down_wraps` increment on their event type in every state.
  - Both saturate at 2^CNT_W−1.
  - Any increment attempted while a tally is at max sets `sat`.
- States:
  - IDLE:
    - `arm` clears `window_wraps`, `up_wraps`, `down_wraps` and `sat`, then moves to ARMED.
    - Events update only the lifetime tallies.
  - ARMED:
    - Each valid event increments `window_wraps` (saturating).
    - If `limit != 0` and the post-increment value is ≥ `limit`, the block moves to FIRED.
  - FIRED:
    - `irq` = 1.
    - `window_wraps` holds; events still update the lifetime tallies.
    - `ack` clears `window_wraps` and returns to ARMED.
- Control priority: `disarm` > `arm` > `ack`.
  - `disarm` forces IDLE and clears `irq`. It does not clear any tally.
  - `arm` is ignored outside IDLE.
  - `ack` is ignored outside FIRED.
- Simultaneous events:
  - ack and an event in the same cycle: the block goes to ARMED with `window_wraps` = 1. If `limit == 1` it goes directly to FIRED instead, so `irq` stays high.
  - arm and an event in the same cycle in IDLE: the clear wins for the lifetime tallies, then the event is applied. The result is tallies of 0/1 and `window_wraps` = 1, and the limit check is applied.
  - disarm and an event in the same cycle: the lifetime tallies update, `window_wraps` is unchanged, and the state becomes IDLE.

## Timing
- All outputs are registered. Event-driven updates are visible one cycle after the edge at which `overflow_in=1, ovf_d=0` is sampled.
- `irq` rises on the same edge at which `window_wraps` reaches `limit`.
- `irq` falls on the edge that samples `ack` or `disarm`.
- Reset (asynchronous, takes effect immediately) sets every output and `ovf_d` to 0, with `state` = IDLE.
  - If `overflow_in` is already high when reset deasserts, no event is generated until `overflow_in` falls and rises again. To guarantee this, `ovf_d` is loaded with `overflow_in` on the first clock after reset.
- Reset in the middle of a window abandons the window. No event is lost or double-counted across the reset edge except the one that is masked.

## Test plan
- Reset, arm, then drive 3 up-wraps (`count_in`=00 with a rising `overflow_in`) → `up_wraps`=3, `window_wraps`=3, `down_wraps`=0, `irq`=0 with `limit`=4.
- `limit`=2, armed, 2 down-wraps (`count_in`=FF) → `irq`=1 and `state`=2 one cycle after the second event. A 3rd event → `down_wraps`=3, `window_wraps`=2. `ack` → `irq`=0, `window_wraps`=0.
- `overflow_in` held high for 10 cycles → exactly 1 event counted. A rising edge with `count_in`=0x37 → no change.
- `ack` and an event in the same cycle with `limit`=1 → `state` stays FIRED, `irq` stays 1, `window_wraps`=1.
- `CNT_W`=4, 16 up-wraps → `up_wraps`=15, `sat`=1. `disarm` keeps the tallies. `arm` clears them and `sat`.
- Reset asserted mid-window while `overflow_in`=1 → all outputs 0 immediately. After release, no event until `overflow_in` toggles 0→1.
